// File: rtl/palindrome_window_stats.sv
// rtl/palindrome_window_stats.sv - per-window hit statistics for the palindrome detector flag
//
// Purpose: samples the palindrome flag every RUN cycle and collects hit count and
// longest consecutive-hit run over fixed windows of WIN_LEN cycles. Publishes one
// report per window over a valid/ready handshake and raises an in-window alarm.
//
// Ports:
//   clk             clock, all flops on posedge
//   reset           asynchronous reset, active-high
//   palindrome_i    palindrome flag sample, one per cycle
//   report_valid_o  report fields valid
//   report_ready_i  consumer accepts report when valid & ready
//   hit_count_o     hits in the reported window
//   max_run_o       longest consecutive-hit run in the reported window
//   alarm_o         in-window hits have reached THRESH
//   drop_o          sticky: a window report was lost
//   total_hits_o    (PAL_STATS_TOTAL_EN only) saturating hit count since reset
//
// Configuration: define PAL_STATS_TOTAL_EN to add the total_hits_o counter.

module palindrome_window_stats #(
    parameter int WIN_LEN = 16,
    parameter int CNT_W   = 8,
    parameter int THRESH  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             palindrome_i,
    output logic             report_valid_o,
    input  logic             report_ready_i,
    output logic [CNT_W-1:0] hit_count_o,
    output logic [CNT_W-1:0] max_run_o,
    output logic             alarm_o,
`ifdef PAL_STATS_TOTAL_EN
    output logic             drop_o,
    output logic [31:0]      total_hits_o
`else
    output logic             drop_o
`endif
);

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } state_t;

    state_t           state;
    logic             warm_cnt;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] max_run;

    logic [CNT_W-1:0] new_hit;
    logic [CNT_W-1:0] new_run;
    logic [CNT_W-1:0] new_max;
    logic             last_sample;
    logic             accept;

    // Statistics as they would stand after including the current sample.
    always_comb begin
        new_hit     = hit_cnt + {{(CNT_W-1){1'b0}}, palindrome_i};
        new_run     = palindrome_i ? run_cnt + 1'b1 : '0;
        new_max     = (new_run > max_run) ? new_run : max_run;
        last_sample = (cyc_cnt == CNT_W'(WIN_LEN - 1));
        accept      = report_valid_o & report_ready_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= WARMUP;
            warm_cnt       <= 1'b0;
            cyc_cnt        <= '0;
            hit_cnt        <= '0;
            run_cnt        <= '0;
            max_run        <= '0;
            report_valid_o <= 1'b0;
            hit_count_o    <= '0;
            max_run_o      <= '0;
            alarm_o        <= 1'b0;
            drop_o         <= 1'b0;
`ifdef PAL_STATS_TOTAL_EN
            total_hits_o   <= '0;
`endif
        end else begin
            // An accepted report retires here; a close on the same edge may reload it below.
            if (accept) begin
                report_valid_o <= 1'b0;
            end

            case (state)
                WARMUP: begin
                    // Upstream flag is not meaningful yet; two cycles are skipped.
                    if (warm_cnt) begin
                        state <= RUN;
                    end else begin
                        warm_cnt <= 1'b1;
                    end
                end

                RUN: begin
`ifdef PAL_STATS_TOTAL_EN
                    if (palindrome_i && (total_hits_o != 32'hFFFF_FFFF)) begin
                        total_hits_o <= total_hits_o + 32'd1;
                    end
`endif
                    if (last_sample) begin
                        cyc_cnt <= '0;
                        hit_cnt <= '0;
                        run_cnt <= '0;
                        max_run <= '0;
                        alarm_o <= 1'b0;
                        // Pending unaccepted report wins; the new one is lost.
                        if (!report_valid_o || accept) begin
                            hit_count_o    <= new_hit;
                            max_run_o      <= new_max;
                            report_valid_o <= 1'b1;
                        end else begin
                            drop_o <= 1'b1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                        hit_cnt <= new_hit;
                        run_cnt <= new_run;
                        max_run <= new_max;
                        if (palindrome_i && (new_hit == CNT_W'(THRESH))) begin
                            alarm_o <= 1'b1;
                        end
                    end
                end

                default: state <= WARMUP;
            endcase
        end
    end

endmodule
